tick_register_arbiter: RTL and testbench

// Shares one TickRegister between NREQ requesters. Each requester posts an
// INC/DEC/SET command with a level request; a round-robin arbiter picks one per

---
 rtl/tick_register_arbiter.sv | 162 ++++++++++++++++
 tb/tb_tick_register_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_register_arbiter.sv
// tick_register_arbiter: NREQ requesters share one SIZE-bit TickRegister through
// a round-robin arbiter; one command is applied per cycle and acked one cycle later.
// Optional feature macro: TICK_REGISTER_ARBITER_SATURATE_EN -- when defined, INC at
// all-ones and DEC at zero hold the counter instead of wrapping (still acked, limit pulses).

`ifndef TICK_REGISTER_MODE_IDLE
`define TICK_REGISTER_MODE_IDLE 2'b00
`endif
`ifndef TICK_REGISTER_MODE_INC
`define TICK_REGISTER_MODE_INC  2'b01
`endif
`ifndef TICK_REGISTER_MODE_DEC
`define TICK_REGISTER_MODE_DEC  2'b10
`endif
`ifndef TICK_REGISTER_MODE_SET
`define TICK_REGISTER_MODE_SET  2'b11
`endif

// Shared modular counter; idle mode holds the value.
module tick_register #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic [SIZE-1:0] val,
    output logic [SIZE-1:0] cnt
);
    // Apply at most one command per edge, wrapping modulo 2^SIZE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case (mode)
                `TICK_REGISTER_MODE_INC: cnt <= cnt + SIZE'(1);
                `TICK_REGISTER_MODE_DEC: cnt <= cnt - SIZE'(1);
                `TICK_REGISTER_MODE_SET: cnt <= val;
                default:                 cnt <= cnt;
            endcase
        end
    end
endmodule

// Per-requester eligibility.
module tick_req_lane (
    input  logic       req,
    input  logic [1:0] mode,
    input  logic       acked,
    output logic       elig
);
    // Only real commands compete; a requester acked this cycle sits out so its
    // still-high level request is not applied twice.
    always_comb begin
        elig = req & ~acked & ((mode == `TICK_REGISTER_MODE_INC) ||
                               (mode == `TICK_REGISTER_MODE_DEC) ||
                               (mode == `TICK_REGISTER_MODE_SET));
    end
endmodule

module tick_register_arbiter #(
    parameter int SIZE = 8,
    parameter int NREQ = 4
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic [NREQ-1:0]      in_req,
    input  logic [2*NREQ-1:0]    in_mode,
    input  logic [SIZE*NREQ-1:0] in_val,
    output logic [NREQ-1:0]      out_ack,
    output logic [SIZE-1:0]      out_val,
    output logic                 out_limit,
    output logic                 out_busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic [1:0]      mode;
        logic [SIZE-1:0] val;
    } cmd_t;

    cmd_t [NREQ-1:0] cmd;
    logic [NREQ-1:0] elig;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_idx;
    logic            win_vld;
    cmd_t            win_cmd;
    logic            limit_hit;
    logic [1:0]      tr_mode;

    // Unpack the flat per-requester buses into command structs.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cmd[i].mode = in_mode[2*i +: 2];
            cmd[i].val  = in_val[SIZE*i +: SIZE];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            tick_req_lane u_lane (
                .req   (in_req[gi]),
                .mode  (cmd[gi].mode),
                .acked (out_ack[gi]),
                .elig  (elig[gi])
            );
        end
    endgenerate

    // Round-robin pick: first eligible index scanning up from the pointer, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_vld && elig[(int'(ptr) + k) % NREQ]) begin
                win_vld = 1'b1;
                win_idx = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // Winner command, boundary detection and the mode actually sent to the counter.
    always_comb begin
        win_cmd   = cmd[win_idx];
        limit_hit = win_vld &&
                    (((win_cmd.mode == `TICK_REGISTER_MODE_INC) && (&out_val)) ||
                     ((win_cmd.mode == `TICK_REGISTER_MODE_DEC) && (out_val == '0)));
        tr_mode   = `TICK_REGISTER_MODE_IDLE;
        if (win_vld) begin
            tr_mode = win_cmd.mode;
`ifdef TICK_REGISTER_ARBITER_SATURATE_EN
            if (limit_hit) tr_mode = `TICK_REGISTER_MODE_IDLE;
`endif
        end
    end

    tick_register #(.SIZE(SIZE)) u_tick (
        .clk  (in_clk),
        .rst  (in_rst),
        .mode (tr_mode),
        .val  (win_cmd.val),
        .cnt  (out_val)
    );

    // Ack/limit pulses and pointer advance; reset drops everything in flight.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_ack   <= '0;
            out_limit <= 1'b0;
            ptr       <= '0;
        end else begin
            out_ack   <= '0;
            out_limit <= limit_hit;
            if (win_vld) begin
                out_ack[win_idx] <= 1'b1;
                ptr <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
            end
        end
    end

    assign out_busy = |elig;
endmodule

// File: tb/tb_tick_register_arbiter.sv
// Bench for tick_register_arbiter: per-cycle comparison against a behavioural
// model plus directed literal checks. Honours TICK_REGISTER_ARBITER_SATURATE_EN.
module tb_tick_register_arbiter;
    localparam int SIZE = 8;
    localparam int NREQ = 4;
    localparam logic [1:0] M_IDLE = 2'b00, M_INC = 2'b01, M_DEC = 2'b10, M_SET = 2'b11;
`ifdef TICK_REGISTER_ARBITER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0]      req  = '0;
    logic [2*NREQ-1:0]    mode = '0;
    logic [SIZE*NREQ-1:0] val  = '0;
    logic [NREQ-1:0]      ack;
    logic [SIZE-1:0]      oval;
    logic                 limit;
    logic                 busy;
    logic [NREQ-1:0]      hold = '0;

    int total = 0;
    int bad   = 0;

    // Model state: what the outputs must show during the current cycle.
    int              m_val   = 0;
    int              m_ptr   = 0;
    logic [NREQ-1:0] m_ack   = '0;
    logic            m_limit = 1'b0;
    logic            started = 1'b0;

    tick_register_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .in_clk    (clk),
        .in_rst    (rst),
        .in_req    (req),
        .in_mode   (mode),
        .in_val    (val),
        .out_ack   (ack),
        .out_val   (oval),
        .out_limit (limit),
        .out_busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] elig_now();
        logic [NREQ-1:0] e;
        for (int i = 0; i < NREQ; i++)
            e[i] = req[i] && (mode[2*i +: 2] != M_IDLE) && !m_ack[i];
        return e;
    endfunction

    // Behavioural model: advance one cycle at each rising edge.
    always @(posedge clk) begin : model
        int w;
        int maxv;
        logic [NREQ-1:0] e;
        logic [1:0] md;
        maxv = (1 << SIZE) - 1;
        e = elig_now();
        started = 1'b1;
        if (rst) begin
            m_val = 0; m_ack = '0; m_limit = 1'b0; m_ptr = 0;
        end else begin
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && e[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            m_ack = '0;
            m_limit = 1'b0;
            if (w >= 0) begin
                md = mode[2*w +: 2];
                if (md == M_SET) begin
                    m_val = int'(val[SIZE*w +: SIZE]);
                end else if (md == M_INC) begin
                    if (m_val == maxv) begin m_limit = 1'b1; if (!SAT) m_val = 0; end
                    else m_val = m_val + 1;
                end else begin
                    if (m_val == 0) begin m_limit = 1'b1; if (!SAT) m_val = maxv; end
                    else m_val = m_val - 1;
                end
                m_ack[w] = 1'b1;
                m_ptr = (w + 1) % NREQ;
            end
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            check("val",   32'(oval),  32'(m_val));
            check("ack",   32'(ack),   32'(m_ack));
            check("limit", 32'(limit), 32'(m_limit));
            check("busy",  32'(busy),  32'(|elig_now()));
        end
    end

    // Advance one cycle; acked requesters that are not held drop their request.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (ack[i] && !hold[i]) req[i] = 1'b0;
        #1;
    endtask

    task automatic post(input int i, input logic [1:0] m, input logic [SIZE-1:0] v);
        req[i] = 1'b1;
        mode[2*i +: 2] = m;
        val[SIZE*i +: SIZE] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        tick(); tick();
        check("rst_val", 32'(oval), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_lim", 32'(limit), 32'h0);
        rst = 1'b0;

        // 1: single SET
        post(0, M_SET, 8'h42); tick();
        check("t1_ack", 32'(ack), 32'b0001);
        check("t1_val", 32'(oval), 32'h42);
        check("t1_lim", 32'(limit), 32'h0);

        // 2: four INCs from pointer 0, one per cycle
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) post(i, M_INC, 8'h00);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("t2_ack", 32'(ack), 32'(1 << n));
            check("t2_val", 32'(oval), 32'(n + 1));
        end

        // 3: INC at all-ones, DEC at zero
        post(0, M_SET, 8'hFF); tick();
        check("t3_set", 32'(oval), 32'hFF);
        post(2, M_INC, 8'h00); tick();
        check("t3_ack", 32'(ack), 32'b0100);
        check("t3_lim", 32'(limit), 32'h1);
        check("t3_val", 32'(oval), SAT ? 32'hFF : 32'h00);
        post(0, M_SET, 8'h00); tick();
        check("t3_set0", 32'(oval), 32'h00);
        post(3, M_DEC, 8'h00); tick();
        check("t3d_ack", 32'(ack), 32'b1000);
        check("t3d_lim", 32'(limit), 32'h1);
        check("t3d_val", 32'(oval), SAT ? 32'h00 : 32'hFF);

        // 4: lone held requester granted every other cycle
        post(0, M_SET, 8'h20); tick();
        hold[1] = 1'b1; post(1, M_INC, 8'h00);
        tick(); check("t4_ack_a", 32'(ack), 32'b0010); check("t4_val_a", 32'(oval), 32'h21);
        tick(); check("t4_ack_b", 32'(ack), 32'b0000); check("t4_val_b", 32'(oval), 32'h21);
        tick(); check("t4_ack_c", 32'(ack), 32'b0010); check("t4_val_c", 32'(oval), 32'h22);
        hold = '0; req[1] = 1'b0;
        tick();

        // 5: reset wins over a pending DEC and clears the pointer
        post(3, M_DEC, 8'h00); rst = 1'b1; tick();
        check("t5_ack", 32'(ack), 32'h0);
        check("t5_val", 32'(oval), 32'h0);
        rst = 1'b0; post(1, M_INC, 8'h00); #1;
        tick();
        check("t5_ack1", 32'(ack), 32'b0010);
        check("t5_val1", 32'(oval), 32'h01);
        tick();
        check("t5_ack3", 32'(ack), 32'b1000);
        check("t5_val3", 32'(oval), 32'h00);

        // 6: idle-mode request is never granted
        post(0, M_IDLE, 8'h55); post(1, M_SET, 8'h10); #1;
        check("t6_busy1", 32'(busy), 32'h1);
        tick();
        check("t6_ack", 32'(ack), 32'b0010);
        check("t6_val", 32'(oval), 32'h10);
        check("t6_busy0", 32'(busy), 32'h0);
        tick();
        check("t6_ack2", 32'(ack), 32'h0);
        check("t6_val2", 32'(oval), 32'h10);
        req = '0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
